dcache_ctrl: RTL



---
 rtl/dcache_pkg.sv | 17 +
 rtl/dcache_array.sv | 58 +++++
 rtl/dcache_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } dcache_state_t;

  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int DEF_SET_ADDR_LEN  = 3;
  localparam int DEF_TAG_ADDR_LEN  = 6;
  localparam int LINE_SIZE         = 1 << DEF_LINE_ADDR_LEN;
  localparam int SET_SIZE          = 1 << DEF_SET_ADDR_LEN;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational lookup, one synchronous write port.
module dcache_array #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SET_ADDR_LEN-1:0]  set,
  input  logic [TAG_ADDR_LEN-1:0]  tag,
  input  logic [LINE_ADDR_LEN-1:0] rd_idx,
  input  logic [LINE_ADDR_LEN-1:0] wr_idx,
  input  logic                     we,
  input  logic [31:0]              wdata,
  input  logic                     mark_dirty,
  input  logic                     commit,
  output logic                     hit,
  output logic                     vic_valid,
  output logic                     vic_dirty,
  output logic [TAG_ADDR_LEN-1:0]  vic_tag,
  output logic [31:0]              rdata
);

  localparam int NWORDS = 1 << LINE_ADDR_LEN;
  localparam int NSETS  = 1 << SET_ADDR_LEN;

  logic [31:0]             data_mem [NSETS][NWORDS];
  logic [TAG_ADDR_LEN-1:0] tag_mem  [NSETS];
  logic [NSETS-1:0]        valid;
  logic [NSETS-1:0]        dirty;

  assign vic_valid = valid[set];
  assign vic_dirty = dirty[set];
  assign vic_tag   = tag_mem[set];
  assign hit       = valid[set] && (tag_mem[set] == tag);
  assign rdata     = data_mem[set][rd_idx];

  // Only the state bits are reset; stale tags are harmless behind valid=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (commit) begin
      valid[set] <= 1'b1;
      dirty[set] <= 1'b0;
    end else if (we && mark_dirty) begin
      dirty[set] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      data_mem[set][wr_idx] <= wdata;
    if (commit)
      tag_mem[set] <= tag;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller: miss FSM, beat
// counter, word-serial memory handshake and miss counter.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
  parameter int TAG_ADDR_LEN  = DEF_TAG_ADDR_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic [31:0] miss_cnt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_gnt
);

  localparam int USED_W = TAG_ADDR_LEN + SET_ADDR_LEN + LINE_ADDR_LEN + 2;

  logic [LINE_ADDR_LEN-1:0] req_word, beat_q, beat_d, rd_idx, wr_idx;
  logic [SET_ADDR_LEN-1:0]  req_set;
  logic [TAG_ADDR_LEN-1:0]  req_tag, vic_tag;
  logic                     req, hit, vic_valid, vic_dirty;
  logic                     arr_we, arr_mark_dirty, arr_commit;
  logic [31:0]              arr_wdata, arr_rdata;
  logic                     unused_addr_bits;
  dcache_state_t            state_q, state_d;

  assign req_word = addr[LINE_ADDR_LEN+1:2];
  assign req_set  = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
  assign req_tag  = addr[USED_W-1:LINE_ADDR_LEN+SET_ADDR_LEN+2];
  assign unused_addr_bits = ^{addr[31:USED_W], addr[1:0]};

  assign req  = rd_req | wr_req;
  assign miss = (state_q != IDLE) | (req & ~hit);

  dcache_array #(
    .LINE_ADDR_LEN(LINE_ADDR_LEN),
    .SET_ADDR_LEN (SET_ADDR_LEN),
    .TAG_ADDR_LEN (TAG_ADDR_LEN)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .set       (req_set),
    .tag       (req_tag),
    .rd_idx    (rd_idx),
    .wr_idx    (wr_idx),
    .we        (arr_we),
    .wdata     (arr_wdata),
    .mark_dirty(arr_mark_dirty),
    .commit    (arr_commit),
    .hit       (hit),
    .vic_valid (vic_valid),
    .vic_dirty (vic_dirty),
    .vic_tag   (vic_tag),
    .rdata     (arr_rdata)
  );

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    arr_we         = 1'b0;
    arr_mark_dirty = 1'b0;
    arr_commit     = 1'b0;
    arr_wdata      = wr_data;
    rd_idx         = req_word;
    wr_idx         = req_word;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          state_d = (vic_valid && vic_dirty) ? WB : FILL;
          beat_d  = '0;
        end else if (wr_req) begin
          arr_we         = 1'b1;
          arr_mark_dirty = 1'b1;
        end
      end
      WB: begin
        rd_idx = beat_q;
        if (mem_gnt) begin
          beat_d = beat_q + 1'b1;
          if (&beat_q)
            state_d = FILL;
        end
      end
      FILL: begin
        wr_idx    = beat_q;
        arr_wdata = mem_rdata;
        if (mem_gnt) begin
          arr_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (&beat_q)
            state_d = DONE;
        end
      end
      DONE: begin
        arr_commit = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory side is decoded from state, so an async reset drops mem_req at once.
  always_comb begin
    mem_req   = (state_q == WB) || (state_q == FILL);
    mem_we    = (state_q == WB);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == WB) begin
      mem_addr  = {{(32-USED_W){1'b0}}, vic_tag, req_set, beat_q, 2'b00};
      mem_wdata = arr_rdata;
    end else if (state_q == FILL) begin
      mem_addr  = {{(32-USED_W){1'b0}}, req_tag, req_set, beat_q, 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      miss_cnt <= '0;
      rd_data  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (state_q == IDLE && req && !hit)
        miss_cnt <= miss_cnt + 32'd1;
      if (state_q == IDLE && rd_req && !wr_req && hit)
        rd_data <= arr_rdata;
    end
  end

  a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (rst) !(rd_req && wr_req));

endmodule
